// File: rtl/csr_access_ctrl.sv
// Zicsr read-modify-write sequencer in front of a one-port, registered-read CSR file.
// Optional access/illegal counters are enabled with CSR_ACCESS_CNT_EN.
module csr_access_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [11:0]     req_idx_i,
  input  logic [XLEN-1:0] req_src_i,
  input  logic            req_rd_nz_i,
  input  logic            req_rs1_nz_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_illegal_o,
  input  logic            trap_valid_i,
  input  logic [11:0]     trap_idx_i,
  input  logic [XLEN-1:0] trap_wdata_i,
  output logic            trap_ready_o,
  output logic            csr_rd_en_o,
  output logic            csr_wr_en_o,
  output logic [11:0]     csr_idx_o,
  output logic [XLEN-1:0] csr_wdata_o,
`ifdef CSR_ACCESS_CNT_EN
  output logic [31:0]     acc_cnt_o,
  output logic [15:0]     illegal_cnt_o,
`endif
  input  logic [XLEN-1:0] csr_rdata_i
);

  typedef enum logic [2:0] {StIdle, StRd, StMod, StRsp, StTwr} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [11:0]     idx_q, idx_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            do_rd_q, do_rd_d;
  logic            do_wr_q, do_wr_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            rsp_illegal_q, rsp_illegal_d;

  logic            req_imm, req_is_rw, req_do_rd, req_do_wr, req_illegal;
  logic [XLEN-1:0] req_opnd, old_val, mod_wdata;

  always_comb begin
    req_imm     = req_op_i[2];
    req_is_rw   = (req_op_i[1:0] == 2'b01);
    req_opnd    = req_imm ? {{(XLEN-5){1'b0}}, req_src_i[4:0]} : req_src_i;
    req_do_rd   = !(req_is_rw && !req_rd_nz_i);
    req_do_wr   = req_is_rw || (req_imm ? (req_src_i[4:0] != 5'd0) : req_rs1_nz_i);
    req_illegal = (req_op_i[1:0] == 2'b00) || (req_do_wr && (req_idx_i[11:10] == 2'b11));
  end

  always_comb begin
    old_val = do_rd_q ? csr_rdata_i : '0;
    unique case (op_q)
      2'b10:   mod_wdata = old_val | opnd_q;
      2'b11:   mod_wdata = old_val & ~opnd_q;
      default: mod_wdata = opnd_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    idx_d         = idx_q;
    opnd_d        = opnd_q;
    do_rd_d       = do_rd_q;
    do_wr_d       = do_wr_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_illegal_d = rsp_illegal_q;
    unique case (state_q)
      StIdle: begin
        if (trap_valid_i) begin
          idx_d   = trap_idx_i;
          opnd_d  = trap_wdata_i;
          state_d = StTwr;
        end else if (req_valid_i) begin
          op_d    = req_op_i[1:0];
          idx_d   = req_idx_i;
          opnd_d  = req_opnd;
          do_rd_d = req_do_rd;
          do_wr_d = req_do_wr;
          if (req_illegal) begin
            rsp_rdata_d   = '0;
            rsp_illegal_d = 1'b1;
            state_d       = StRsp;
          end else if (req_do_rd) begin
            state_d = StRd;
          end else begin
            state_d = StMod;
          end
        end
      end
      StRd:  state_d = StMod;
      StMod: begin
        rsp_rdata_d   = old_val;
        rsp_illegal_d = 1'b0;
        state_d       = StRsp;
      end
      StRsp:   state_d = StIdle;
      StTwr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      op_q          <= '0;
      idx_q         <= '0;
      opnd_q        <= '0;
      do_rd_q       <= 1'b0;
      do_wr_q       <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      idx_q         <= idx_d;
      opnd_q        <= opnd_d;
      do_rd_q       <= do_rd_d;
      do_wr_q       <= do_wr_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  // Outputs are forced low while reset is held so an in-flight write is dropped at once.
  always_comb begin
    req_ready_o   = 1'b0;
    trap_ready_o  = 1'b0;
    rsp_valid_o   = 1'b0;
    rsp_rdata_o   = '0;
    rsp_illegal_o = 1'b0;
    csr_rd_en_o   = 1'b0;
    csr_wr_en_o   = 1'b0;
    csr_idx_o     = '0;
    csr_wdata_o   = '0;
    if (rst_ni) begin
      trap_ready_o  = (state_q == StIdle);
      req_ready_o   = (state_q == StIdle) && !trap_valid_i;
      rsp_valid_o   = (state_q == StRsp);
      rsp_rdata_o   = rsp_rdata_q;
      rsp_illegal_o = rsp_illegal_q;
      csr_rd_en_o   = (state_q == StRd);
      csr_wr_en_o   = (state_q == StTwr) || ((state_q == StMod) && do_wr_q);
      if (csr_rd_en_o || csr_wr_en_o) begin
        csr_idx_o = idx_q;
      end
      if (state_q == StTwr) begin
        csr_wdata_o = opnd_q;
      end else if (csr_wr_en_o) begin
        csr_wdata_o = mod_wdata;
      end
    end
  end

`ifdef CSR_ACCESS_CNT_EN
  logic [31:0] acc_cnt_q;
  logic [15:0] illegal_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_cnt_q     <= '0;
      illegal_cnt_q <= '0;
    end else begin
      if (csr_wr_en_o) begin
        acc_cnt_q <= acc_cnt_q + 32'd1;
      end
      if ((state_q == StRsp) && rsp_illegal_q) begin
        illegal_cnt_q <= illegal_cnt_q + 16'd1;
      end
    end
  end

  assign acc_cnt_o     = rst_ni ? acc_cnt_q : '0;
  assign illegal_cnt_o = rst_ni ? illegal_cnt_q : '0;
`endif

endmodule
